// File: rtl/keep_talking_pkg.sv
// Shared definitions for the bomb-game control blocks: arbiter state encodings, system clock rate.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keep_talking_pkg;

   localparam int CLK_HZ = 27000000;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_ISSUE   = 2'b01,
      ARB_HOLDOFF = 2'b10,
      ARB_HALT    = 2'b11
   } arb_state_t;

endpackage

// File: rtl/strike_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping to the lowest set bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the pick.
// Ports: req (request vector), ptr (search start), vld (any request), idx (chosen index).
module rr_pick #(
   parameter int N = 6,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         vld,
   output logic [W-1:0] idx
);

   logic         any_hit;
   logic         hi_hit;
   logic [W-1:0] any_idx;
   logic [W-1:0] hi_idx;

   // Walk downwards so the last assignment wins, leaving the lowest matching
   // index. hi_* covers positions at/after ptr; any_* is the wrap-around fallback.
   always_comb begin
      any_hit = 1'b0;
      hi_hit  = 1'b0;
      any_idx = '0;
      hi_idx  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            any_hit = 1'b1;
            any_idx = W'(i);
            if (W'(i) >= ptr) begin
               hi_hit = 1'b1;
               hi_idx = W'(i);
            end
         end
      end
      vld = any_hit;
      idx = hi_hit ? hi_idx : any_idx;
   end

endmodule

// File: rtl/strike_arbiter.sv
// Serialises puzzle-module strike requests into single, spaced strike pulses (round-robin fair).
// Latency: request edge in cycle t -> pending in t+1 -> strike_out in t+2 (from IDLE).
// Backpressure: one outstanding request per module; further rises absorbed until it issues.
// Ports: clock, reset (sync, active-high), armed, exploded, mod_strike[NUM_MODULES-1:0] in;
//        strike_out, strike_src[ID_W-1:0], pending[NUM_MODULES-1:0], busy out.
// Optional: define STRIKE_BUZZER_EN to add parameter BUZZ_CYCLES and output buzzer.
module strike_arbiter
   import keep_talking_pkg::*;
#(
   parameter int NUM_MODULES    = 6,
   parameter int HOLDOFF_CYCLES = 13500000,
`ifdef STRIKE_BUZZER_EN
   parameter int BUZZ_CYCLES    = 2700000,
`endif
   parameter int ID_W           = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   armed,
   input  logic                   exploded,
   input  logic [NUM_MODULES-1:0] mod_strike,
   output logic                   strike_out,
   output logic [ID_W-1:0]        strike_src,
   output logic [NUM_MODULES-1:0] pending,
`ifdef STRIKE_BUZZER_EN
   output logic                   buzzer,
`endif
   output logic                   busy
);

   // Counter only ever holds HOLDOFF_CYCLES-1 down to 0.
   localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   arb_state_t             state, state_nxt;
   logic [NUM_MODULES-1:0] prev;
   logic [NUM_MODULES-1:0] req_rise;
   logic [NUM_MODULES-1:0] set_mask;
   logic [NUM_MODULES-1:0] clr_mask;
   logic [NUM_MODULES-1:0] pending_nxt;
   logic [ID_W-1:0]        ptr;
   logic [CNT_W-1:0]       cnt;
   logic                   pick_vld;
   logic [ID_W-1:0]        pick_idx;
   logic                   sel_go;

   assign req_rise = mod_strike & ~prev;

   rr_pick #(
      .N (NUM_MODULES),
      .W (ID_W)
   ) u_pick (
      .req (pending),
      .ptr (ptr),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   always_comb begin
      state_nxt = state;
      sel_go    = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (exploded) begin
               state_nxt = ARB_HALT;
            end else if (armed && pick_vld) begin
               sel_go    = 1'b1;
               state_nxt = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            // The pulse for this cycle is already on the output; explosion only
            // redirects where we go next.
            state_nxt = exploded ? ARB_HALT : ARB_HOLDOFF;
         end
         ARB_HOLDOFF: begin
            if (exploded) begin
               state_nxt = ARB_HALT;
            end else if (cnt == '0) begin
               state_nxt = ARB_IDLE;
            end
         end
         ARB_HALT: begin
            state_nxt = ARB_HALT;
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   // A new rise on the module being selected this cycle survives the clear:
   // set is OR-ed in after the clear mask. Entering or sitting in HALT wipes everything.
   always_comb begin
      set_mask    = (armed && (state != ARB_HALT)) ? req_rise : '0;
      clr_mask    = sel_go ? (NUM_MODULES'(1) << pick_idx) : '0;
      pending_nxt = (pending & ~clr_mask) | set_mask;
      if (state_nxt == ARB_HALT) begin
         pending_nxt = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ARB_IDLE;
         prev       <= '0;
         pending    <= '0;
         ptr        <= '0;
         cnt        <= '0;
         strike_src <= '0;
      end else begin
         state   <= state_nxt;
         prev    <= mod_strike;
         pending <= pending_nxt;
         if (sel_go) begin
            strike_src <= pick_idx;
            ptr        <= (pick_idx == ID_W'(NUM_MODULES - 1)) ? '0 : pick_idx + ID_W'(1);
         end
         if (state == ARB_ISSUE) begin
            cnt <= CNT_W'(HOLDOFF_CYCLES - 1);
         end else if ((state == ARB_HOLDOFF) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Both decoded straight from the state register, so they are glitch-free
   // registered outputs.
   assign strike_out = (state == ARB_ISSUE);
   assign busy       = (state == ARB_ISSUE) || (state == ARB_HOLDOFF);

`ifdef STRIKE_BUZZER_EN
   localparam int BZ_W = $clog2(BUZZ_CYCLES + 1);

   logic [BZ_W-1:0] buzz_cnt;

   // Loaded on the edge that enters ISSUE so buzzer rises together with
   // strike_out; a new strike simply reloads it.
   always_ff @(posedge clock) begin
      if (reset) begin
         buzz_cnt <= '0;
      end else if (sel_go) begin
         buzz_cnt <= BZ_W'(BUZZ_CYCLES);
      end else if (buzz_cnt != '0) begin
         buzz_cnt <= buzz_cnt - BZ_W'(1);
      end
   end

   assign buzzer = (buzz_cnt != '0) || (state == ARB_HALT);
`endif

endmodule

// File: tb/tb_strike_arbiter.sv
// Directed bench for strike_arbiter with NUM_MODULES=6, HOLDOFF_CYCLES=4, ID_W=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_strike_arbiter;

   logic       clock;
   logic       reset;
   logic       armed;
   logic       exploded;
   logic [5:0] mod_strike;
   logic       strike_out;
   logic [2:0] strike_src;
   logic [5:0] pending;
   logic       busy;
`ifdef STRIKE_BUZZER_EN
   logic       buzzer;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   strike_arbiter #(
      .NUM_MODULES    (6),
      .HOLDOFF_CYCLES (4),
      .ID_W           (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .armed      (armed),
      .exploded   (exploded),
      .mod_strike (mod_strike),
      .strike_out (strike_out),
      .strike_src (strike_src),
      .pending    (pending),
`ifdef STRIKE_BUZZER_EN
      .buzzer     (buzzer),
`endif
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (strike_out) pulses++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; armed = 1'b1; exploded = 1'b0; mod_strike = 6'b111111;
      step();
      step();
      n_checks++;
      if (pending !== 6'b000000) begin n_fail++; $display("FAIL reset_pending: got %b expected 000000", pending); end
      n_checks++;
      if (strike_out !== 1'b0 || busy !== 1'b0 || strike_src !== 3'd0) begin
         n_fail++; $display("FAIL reset_outputs: got so=%b busy=%b src=%0d expected 0 0 0", strike_out, busy, strike_src);
      end
      mod_strike = 6'b000000;
      reset = 1'b0;
   endtask

   task automatic test_single();
      int p;
      armed = 1'b1;
      mod_strike = 6'b000100;
      step();
      n_checks++;
      if (pending !== 6'b000100 || strike_out !== 1'b0) begin
         n_fail++; $display("FAIL single_latch: got pend=%b so=%b expected 000100 0", pending, strike_out);
      end
      mod_strike = 6'b000000;
      step();
      n_checks++;
      if (strike_out !== 1'b1 || strike_src !== 3'd2 || pending !== 6'b000000 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_issue: got so=%b src=%0d pend=%b busy=%b expected 1 2 000000 1", strike_out, strike_src, pending, busy);
      end
      count_pulses(6, p);
      n_checks++;
      if (p !== 1'b0 + 0) begin n_fail++; $display("FAIL single_extra: got %0d pulses expected 0", p); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int         pc[3];
      logic [2:0] ps[3];
      int         np = 0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      mod_strike = 6'b101001;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 1) begin
            mod_strike = 6'b000000;
            n_checks++;
            if (pending !== 6'b101001) begin n_fail++; $display("FAIL b2b_latch: got %b expected 101001", pending); end
         end
         if (c == 2) begin
            n_checks++;
            if (pending !== 6'b101000) begin n_fail++; $display("FAIL b2b_clear0: got %b expected 101000", pending); end
         end
         if (strike_out) begin
            if (np < 3) begin pc[np] = c; ps[np] = strike_src; end
            np++;
         end
      end
      n_checks++;
      if (np !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d pulses expected 3", np); end
      else begin
         n_checks++;
         if (pc[0] !== 2 || pc[1] !== 8 || pc[2] !== 14) begin
            n_fail++; $display("FAIL b2b_timing: got %0d %0d %0d expected 2 8 14", pc[0], pc[1], pc[2]);
         end
         n_checks++;
         if (ps[0] !== 3'd0 || ps[1] !== 3'd3 || ps[2] !== 3'd5) begin
            n_fail++; $display("FAIL b2b_order: got %0d %0d %0d expected 0 3 5", ps[0], ps[1], ps[2]);
         end
      end
   endtask

   task automatic test_held_level();
      int p;
      mod_strike = 6'b000010;
      count_pulses(100, p);
      n_checks++;
      if (p !== 1) begin n_fail++; $display("FAIL held_once: got %0d pulses expected 1", p); end
      mod_strike = 6'b000000;
      step();
      mod_strike = 6'b000010;
      count_pulses(10, p);
      n_checks++;
      if (p !== 1 || strike_src !== 3'd1) begin
         n_fail++; $display("FAIL held_rerise: got %0d pulses src=%0d expected 1 1", p, strike_src);
      end
      mod_strike = 6'b000000;
      count_pulses(4, p);
   endtask

   task automatic test_disarmed();
      int p;
      armed = 1'b0;
      mod_strike = 6'b010001;
      step();
      n_checks++;
      if (pending !== 6'b000000) begin n_fail++; $display("FAIL disarm_latch: got %b expected 000000", pending); end
      mod_strike = 6'b000000;
      count_pulses(10, p);
      n_checks++;
      if (p !== 0) begin n_fail++; $display("FAIL disarm_pulse: got %0d pulses expected 0", p); end
      armed = 1'b1;
      count_pulses(10, p);
      n_checks++;
      if (p !== 0 || pending !== 6'b000000) begin
         n_fail++; $display("FAIL rearm_pulse: got %0d pulses pend=%b expected 0 000000", p, pending);
      end
   endtask

   task automatic test_explode();
      int   p = 0;
      logic seen = 1'b0;
      mod_strike = 6'b000100;
      step();
      mod_strike = 6'b000000;
      step();
      n_checks++;
      if (strike_out !== 1'b1) begin n_fail++; $display("FAIL explode_setup: got so=%b expected 1", strike_out); end
      step();
      mod_strike = 6'b010000;
      step();
      mod_strike = 6'b000000;
      n_checks++;
      if (pending !== 6'b010000 || busy !== 1'b1) begin
         n_fail++; $display("FAIL explode_pre: got pend=%b busy=%b expected 010000 1", pending, busy);
      end
      exploded = 1'b1;
      step();
      exploded = 1'b0;
      n_checks++;
      if (pending !== 6'b000000 || busy !== 1'b0 || strike_out !== 1'b0) begin
         n_fail++; $display("FAIL explode_halt: got pend=%b busy=%b so=%b expected 000000 0 0", pending, busy, strike_out);
      end
      for (int i = 0; i < 50; i++) begin
         mod_strike = (i % 4 == 0) ? 6'b111111 : 6'b000000;
         step();
         if (strike_out) p++;
         if (pending != 6'b000000) seen = 1'b1;
      end
      mod_strike = 6'b000000;
      n_checks++;
      if (p !== 0 || seen !== 1'b0) begin
         n_fail++; $display("FAIL halt_quiet: got %0d pulses pend_seen=%b expected 0 0", p, seen);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if (strike_out !== 1'b0 || busy !== 1'b0 || pending !== 6'b000000 || strike_src !== 3'd0) begin
         n_fail++; $display("FAIL halt_reset: got so=%b busy=%b pend=%b src=%0d expected 0 0 000000 0", strike_out, busy, pending, strike_src);
      end
      mod_strike = 6'b000010;
      step();
      mod_strike = 6'b000000;
      step();
      n_checks++;
      if (strike_out !== 1'b1 || strike_src !== 3'd1) begin
         n_fail++; $display("FAIL post_halt_issue: got so=%b src=%0d expected 1 1", strike_out, strike_src);
      end
      count_pulses(6, p);
   endtask

   task automatic test_reset_on_issue();
      int p;
      mod_strike = 6'b001000;
      step();
      mod_strike = 6'b100000;
      step();
      mod_strike = 6'b000000;
      n_checks++;
      if (strike_out !== 1'b1 || strike_src !== 3'd3 || pending !== 6'b100000) begin
         n_fail++; $display("FAIL roi_issue: got so=%b src=%0d pend=%b expected 1 3 100000", strike_out, strike_src, pending);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if (strike_out !== 1'b0 || busy !== 1'b0 || pending !== 6'b000000 || strike_src !== 3'd0) begin
         n_fail++; $display("FAIL roi_reset: got so=%b busy=%b pend=%b src=%0d expected 0 0 000000 0", strike_out, busy, pending, strike_src);
      end
      count_pulses(10, p);
      n_checks++;
      if (p !== 0) begin n_fail++; $display("FAIL roi_quiet: got %0d pulses expected 0", p); end
   endtask

   initial begin
      reset = 1'b1; armed = 1'b0; exploded = 1'b0; mod_strike = 6'b000000;
      test_reset();
      test_single();
      test_back_to_back();
      test_held_level();
      test_disarmed();
      test_explode();
      test_reset_on_issue();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
